// File: rtl/riscv_pkg.sv
// Shared fetch-path types and helpers for the C-extension span sequencer and the
// instruction aligner.
package riscv_pkg;

    typedef enum logic [1:0] {
        HOLDOFF   = 2'd0,
        RUN       = 2'd1,
        SPAN_WAIT = 2'd2
    } span_state_e;

    localparam int FetchLatency = 2;
    localparam int ParcelW      = 16;

    // A parcel whose low two bits are not 2'b11 is a 16-bit compressed instruction.
    function automatic logic is_compressed_parcel(input logic [ParcelW-1:0] parcel);
        return parcel[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/fetch_holdoff_timer.sv
// Reloadable down-counter that measures the fetch latency after a redirect;
// o_zero marks the last holdoff cycle.
module fetch_holdoff_timer #(
    parameter int FETCH_LATENCY = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_load,
    input  logic i_dec,
    output logic o_zero
);

    localparam int W = (FETCH_LATENCY > 1) ? $clog2(FETCH_LATENCY) : 1;
    localparam logic [W-1:0] ReloadVal = W'(FETCH_LATENCY - 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= ReloadVal;
        end else if (i_load) begin
            r_cnt <= ReloadVal;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/c_ext_span_sequencer.sv
// IF-stage sequencer for 32-bit instructions straddling a fetch-word boundary.
// Optional span-stall counter enabled by defining FROST_SPAN_PERF_CNT_EN.
module c_ext_span_sequencer
    import riscv_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter int FETCH_LATENCY = FetchLatency,
    parameter int CNT_W         = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_stall,
    input  logic             i_flush,
    input  logic             i_flush_target_hw,
    input  logic             i_fetch_valid,
    input  logic [31:0]      i_fetch_word,
    input  logic             i_pc_reg_hw,
    output logic [31:0]      o_instr,
    output logic             o_instr_valid,
    output logic             o_is_compressed,
    output logic             o_is_32bit_spanning,
    output logic             o_spanning_wait_for_fetch,
    output logic             o_spanning_in_progress,
    output logic             o_spanning_to_halfword,
    output logic             o_spanning_to_halfword_r,
    output logic             o_control_flow_to_halfword_r,
    output logic             o_any_holdoff,
    output logic [CNT_W-1:0] o_span_stall_count
);

    if (FETCH_LATENCY < 1) begin : g_bad_latency
        $error("FETCH_LATENCY must be at least 1");
    end
    if ((XLEN != 32) && (XLEN != 64)) begin : g_bad_xlen
        $error("XLEN must be 32 or 64");
    end

    span_state_e        r_state;
    span_state_e        w_next_state;
    logic [ParcelW-1:0] r_span_buf;
    logic               r_any_holdoff;
    logic               r_to_halfword_r;
    logic               r_cf_to_halfword_r;
    logic               w_timer_zero;
    logic [ParcelW-1:0] w_parcel;
    logic [31:0]        w_instr;
    logic               w_valid;
    logic               w_compressed;
    logic               w_span_start;
    logic               w_wait;
    logic               w_in_prog;
    logic               w_to_hw;

    fetch_holdoff_timer #(
        .FETCH_LATENCY(FETCH_LATENCY)
    ) u_holdoff_timer (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_load (i_flush),
        .i_dec  ((r_state == HOLDOFF) && !i_stall),
        .o_zero (w_timer_zero)
    );

    assign w_parcel = i_pc_reg_hw ? i_fetch_word[31:16] : i_fetch_word[15:0];

    always_comb begin
        w_next_state = r_state;
        w_instr      = 32'b0;
        w_valid      = 1'b0;
        w_compressed = 1'b0;
        w_span_start = 1'b0;
        w_wait       = 1'b0;
        w_in_prog    = 1'b0;
        w_to_hw      = 1'b0;
        case (r_state)
            HOLDOFF: begin
                if (w_timer_zero) w_next_state = RUN;
            end
            RUN: begin
                if (i_fetch_valid) begin
                    if (is_compressed_parcel(w_parcel)) begin
                        w_instr      = {16'b0, w_parcel};
                        w_valid      = 1'b1;
                        w_compressed = 1'b1;
                    end else if (i_pc_reg_hw) begin
                        w_span_start = 1'b1;
                        w_next_state = SPAN_WAIT;
                    end else begin
                        w_instr = i_fetch_word;
                        w_valid = 1'b1;
                    end
                end
            end
            SPAN_WAIT: begin
                if (i_fetch_valid) begin
                    w_instr      = {i_fetch_word[15:0], r_span_buf};
                    w_valid      = 1'b1;
                    w_in_prog    = 1'b1;
                    w_to_hw      = 1'b1;
                    w_next_state = RUN;
                end else begin
                    w_wait = 1'b1;
                end
            end
            default: w_next_state = HOLDOFF;
        endcase
        // A redirect squashes everything decoded this cycle.
        if (i_flush) begin
            w_next_state = HOLDOFF;
            w_instr      = 32'b0;
            w_valid      = 1'b0;
            w_compressed = 1'b0;
            w_span_start = 1'b0;
            w_wait       = 1'b0;
            w_in_prog    = 1'b0;
            w_to_hw      = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state            <= HOLDOFF;
            r_span_buf         <= '0;
            r_any_holdoff      <= 1'b1;
            r_to_halfword_r    <= 1'b0;
            r_cf_to_halfword_r <= 1'b0;
        end else if (i_flush) begin
            r_state            <= HOLDOFF;
            r_span_buf         <= '0;
            r_any_holdoff      <= 1'b1;
            r_to_halfword_r    <= 1'b0;
            r_cf_to_halfword_r <= i_flush_target_hw;
        end else if (!i_stall) begin
            r_state         <= w_next_state;
            r_any_holdoff   <= (w_next_state == HOLDOFF);
            r_to_halfword_r <= w_to_hw;
            if (w_span_start) r_span_buf <= i_fetch_word[31:16];
            if ((r_state == RUN) && w_valid) r_cf_to_halfword_r <= 1'b0;
        end
    end

    assign o_instr                      = w_instr;
    assign o_instr_valid                = w_valid;
    assign o_is_compressed              = w_compressed;
    assign o_is_32bit_spanning          = w_span_start;
    assign o_spanning_wait_for_fetch    = w_wait;
    assign o_spanning_in_progress       = w_in_prog;
    assign o_spanning_to_halfword       = w_to_hw;
    assign o_spanning_to_halfword_r     = r_to_halfword_r;
    assign o_control_flow_to_halfword_r = r_cf_to_halfword_r;
    assign o_any_holdoff                = r_any_holdoff;

`ifdef FROST_SPAN_PERF_CNT_EN
    logic [CNT_W-1:0] r_span_stall_cnt;

    // Saturating; only reset clears it so software can sample it at leisure.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_span_stall_cnt <= '0;
        end else if (w_wait && !i_stall && (r_span_stall_cnt != '1)) begin
            r_span_stall_cnt <= r_span_stall_cnt + 1'b1;
        end
    end

    assign o_span_stall_count = r_span_stall_cnt;
`else
    assign o_span_stall_count = '0;
`endif

endmodule

// File: tb/tb_c_ext_span_sequencer.sv
// Randomized and directed bench for c_ext_span_sequencer against a cycle-level
// model built from the fetch-sequencing rules.
module tb_c_ext_span_sequencer;

    localparam int FL    = 2;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             i_rst, i_stall, i_flush, i_flush_target_hw;
    logic             i_fetch_valid, i_pc_reg_hw;
    logic [31:0]      i_fetch_word;
    logic [31:0]      o_instr;
    logic             o_instr_valid, o_is_compressed, o_is_32bit_spanning;
    logic             o_spanning_wait_for_fetch, o_spanning_in_progress;
    logic             o_spanning_to_halfword, o_spanning_to_halfword_r;
    logic             o_control_flow_to_halfword_r, o_any_holdoff;
    logic [CNT_W-1:0] o_span_stall_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: holdoff cycles remaining, a pending upper parcel, and the sticky flags.
    int          m_hold;
    bit          m_pend;
    logic [15:0] m_upper;
    bit          m_to_hw_r, m_cf_r;
    logic [31:0] m_cnt;

    logic [31:0] e_instr;
    bit          e_valid, e_comp, e_span, e_wait, e_prog, e_tohw;

    always #5 clk = ~clk;

    c_ext_span_sequencer #(.XLEN(32), .FETCH_LATENCY(FL), .CNT_W(CNT_W)) dut (
        .i_clk                        (clk),
        .i_rst                        (i_rst),
        .i_stall                      (i_stall),
        .i_flush                      (i_flush),
        .i_flush_target_hw            (i_flush_target_hw),
        .i_fetch_valid                (i_fetch_valid),
        .i_fetch_word                 (i_fetch_word),
        .i_pc_reg_hw                  (i_pc_reg_hw),
        .o_instr                      (o_instr),
        .o_instr_valid                (o_instr_valid),
        .o_is_compressed              (o_is_compressed),
        .o_is_32bit_spanning          (o_is_32bit_spanning),
        .o_spanning_wait_for_fetch    (o_spanning_wait_for_fetch),
        .o_spanning_in_progress       (o_spanning_in_progress),
        .o_spanning_to_halfword       (o_spanning_to_halfword),
        .o_spanning_to_halfword_r     (o_spanning_to_halfword_r),
        .o_control_flow_to_halfword_r (o_control_flow_to_halfword_r),
        .o_any_holdoff                (o_any_holdoff),
        .o_span_stall_count           (o_span_stall_count)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_hold    = FL;
        m_pend    = 1'b0;
        m_upper   = '0;
        m_to_hw_r = 1'b0;
        m_cf_r    = 1'b0;
        m_cnt     = '0;
    endtask

    task automatic predict();
        logic [15:0] par;
        e_instr = '0; e_valid = 0; e_comp = 0; e_span = 0; e_wait = 0; e_prog = 0; e_tohw = 0;
        if (!i_rst && !i_flush && m_hold == 0) begin
            if (m_pend) begin
                if (i_fetch_valid) begin
                    e_instr = {i_fetch_word[15:0], m_upper};
                    e_valid = 1; e_prog = 1; e_tohw = 1;
                end else begin
                    e_wait = 1;
                end
            end else if (i_fetch_valid) begin
                par = i_pc_reg_hw ? i_fetch_word[31:16] : i_fetch_word[15:0];
                if (par[1:0] != 2'b11) begin
                    e_instr = {16'h0000, par}; e_valid = 1; e_comp = 1;
                end else if (i_pc_reg_hw) begin
                    e_span = 1;
                end else begin
                    e_instr = i_fetch_word; e_valid = 1;
                end
            end
        end
    endtask

    task automatic advance();
        if (i_flush) begin
            m_hold = FL; m_pend = 0; m_upper = '0; m_cf_r = i_flush_target_hw; m_to_hw_r = 0;
        end else if (!i_stall) begin
            if (e_wait && m_cnt != 32'hFFFF_FFFF) m_cnt++;
            m_to_hw_r = e_tohw;
            if (e_valid && !m_pend) m_cf_r = 0;
            if (m_hold > 0) m_hold--;
            else if (m_pend) begin
                if (i_fetch_valid) m_pend = 0;
            end else if (e_span) begin
                m_pend = 1; m_upper = i_fetch_word[31:16];
            end
        end
    endtask

    task automatic check_all();
        logic [31:0] exp_cnt;
`ifdef FROST_SPAN_PERF_CNT_EN
        exp_cnt = m_cnt;
`else
        exp_cnt = '0;
`endif
        check_val("instr",       o_instr,                      e_instr);
        check_val("instr_valid", 32'(o_instr_valid),           32'(e_valid));
        check_val("compressed",  32'(o_is_compressed),         32'(e_comp));
        check_val("span_start",  32'(o_is_32bit_spanning),     32'(e_span));
        check_val("span_wait",   32'(o_spanning_wait_for_fetch), 32'(e_wait));
        check_val("span_prog",   32'(o_spanning_in_progress),  32'(e_prog));
        check_val("to_hw",       32'(o_spanning_to_halfword),  32'(e_tohw));
        check_val("to_hw_r",     32'(o_spanning_to_halfword_r), 32'(m_to_hw_r));
        check_val("cf_hw_r",     32'(o_control_flow_to_halfword_r), 32'(m_cf_r));
        check_val("holdoff",     32'(o_any_holdoff),           32'(m_hold > 0));
        check_val("stall_cnt",   o_span_stall_count,           exp_cnt);
    endtask

    task automatic cycle(input bit st, input bit fl, input bit tg, input bit fv,
                         input bit hw, input logic [31:0] w);
        @(negedge clk);
        i_rst = 0; i_stall = st; i_flush = fl; i_flush_target_hw = tg;
        i_fetch_valid = fv; i_pc_reg_hw = hw; i_fetch_word = w;
        #1;
        predict();
        check_all();
        advance();
    endtask

    // Reset asserted between clock edges to exercise the asynchronous path.
    task automatic async_reset();
        @(negedge clk);
        #2;
        i_rst = 1;
        #1;
        model_reset();
        predict();
        check_all();
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        logic [31:0] w;
        i_rst = 1; i_stall = 0; i_flush = 0; i_flush_target_hw = 0;
        i_fetch_valid = 0; i_pc_reg_hw = 0; i_fetch_word = '0;
        model_reset();
        #1;
        predict();
        check_all();
        @(posedge clk);

        // Holdoff after reset lasts FL cycles.
        cycle(0, 0, 0, 1, 0, 32'h0000_0001);
        check_val("rst_holdoff_c1", 32'(o_any_holdoff), 32'd1);
        cycle(0, 0, 0, 1, 0, 32'h0000_0001);
        check_val("rst_holdoff_c2", 32'(o_any_holdoff), 32'd1);

        // Span across words: upper parcel 0x0013, next lower parcel 0x0513.
        cycle(0, 0, 0, 1, 1, 32'h0013_0000);
        check_val("span_detect", 32'(o_is_32bit_spanning), 32'd1);
        cycle(0, 0, 0, 1, 0, 32'hABCD_0513);
        check_val("span_instr", o_instr, 32'h0513_0013);
        cycle(0, 0, 0, 1, 0, 32'h4501_4505);
        check_val("to_hw_r_after", 32'(o_spanning_to_halfword_r), 32'd1);
        check_val("c_lo", o_instr, 32'h0000_4505);
        cycle(0, 0, 0, 1, 1, 32'h4501_4505);
        check_val("c_hi", o_instr, 32'h0000_4501);

        // Span with three missing fetch words.
        cycle(0, 0, 0, 1, 1, 32'h0013_0000);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0, 0, 0, 32'hDEAD_BEEF);
            check_val("wait_fetch", 32'(o_spanning_wait_for_fetch), 32'd1);
        end
        cycle(0, 0, 0, 1, 0, 32'h1111_0513);

        // Flush to a halfword target while waiting for the second parcel.
        cycle(0, 0, 0, 1, 1, 32'h0013_0000);
        cycle(0, 1, 1, 1, 0, 32'h2222_0513);
        check_val("flush_valid", 32'(o_instr_valid), 32'd0);
        for (int i = 0; i < FL; i++) cycle(0, 0, 0, 1, 1, 32'h4501_4505);
        check_val("cf_hw_held", 32'(o_control_flow_to_halfword_r), 32'd1);
        cycle(0, 0, 0, 1, 1, 32'h4501_4505);
        cycle(0, 0, 0, 1, 1, 32'h4501_4505);
        check_val("cf_hw_clear", 32'(o_control_flow_to_halfword_r), 32'd0);

        // Stall in SPAN_WAIT with valid data, then reset mid-stall.
        cycle(0, 0, 0, 1, 1, 32'h0013_0000);
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, 1, 0, 32'h3333_0513);
        async_reset();
        check_val("rst_mid_valid", 32'(o_instr_valid), 32'd0);

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                async_reset();
            end else begin
                w = $urandom;
                if ($urandom_range(0, 1) == 1) w[1:0] = 2'b11;
                if ($urandom_range(0, 1) == 1) w[17:16] = 2'b11;
                cycle($urandom_range(0, 99) < 15, $urandom_range(0, 99) < 4,
                      $urandom_range(0, 1) == 1, $urandom_range(0, 99) < 70,
                      $urandom_range(0, 1) == 1, w);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
